// File: rtl/joybus_frame_rx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// joybus_frame_rx
//
// Receiver for the N64 Joybus single-wire line. Each data bit is a low pulse
// followed by a high pulse. A short low (under two microseconds) is a '1' and
// a long low is a '0'. Bits arrive MSB first, and a short stop pulse closes
// the frame. A good frame is presented on data_out with a one-cycle
// data_valid strobe. A malformed or stalled frame produces a one-cycle
// frame_err strobe and leaves data_out untouched.
//
// Ports
//   clk_in      sole clock
//   rst         synchronous, active-high reset
//   enable      receive enable; low parks the receiver and suppresses strobes
//   din         raw asynchronous Joybus line, idle high
//   data_out    last good frame, MSB = first bit received
//   data_valid  one-cycle pulse, data_out updated this cycle
//   frame_err   one-cycle pulse, frame aborted
//   busy        high while a frame is in progress
// ----------------------------------------------------------------------------
module joybus_frame_rx #(
    parameter int NBITS       = 32,
    parameter int CLKS_PER_US = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_US  = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             din,
    output logic [NBITS-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int TMO = TIMEOUT_US * CLKS_PER_US;
    localparam int CW  = $clog2(TMO + 1);
    localparam int IW  = $clog2(NBITS + 1);

    localparam logic [CW-1:0] THR_C   = CW'(2 * CLKS_PER_US);
    localparam logic [CW-1:0] TMO_C   = CW'(TMO);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [IW-1:0] NBITS_C = IW'(NBITS);

    localparam logic [1:0] WAIT_HIGH = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] LOW       = 2'd2;
    localparam logic [1:0] HIGH      = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] primed_q;
    logic                   s_prev_q;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          phase_cnt_q, phase_cnt_d;
    logic [IW-1:0]          bit_idx_q, bit_idx_d;
    logic [NBITS-1:0]       shift_q, shift_d;
    logic [NBITS-1:0]       data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic          s;
    logic          primed;
    logic          fall;
    logic          rise;
    logic [CW-1:0] cnt_inc;

    assign s      = sync_q[SYNC_STAGES-1];
    // The synchroniser flops reset to 1, so s reads high for a few cycles
    // after reset whatever the line is doing. primed marks the point where
    // s carries a genuine sample of din again, so that a line still held
    // low at reset release is not mistaken for idle.
    assign primed = primed_q[SYNC_STAGES-1];
    assign fall   = s_prev_q & ~s;
    assign rise   = ~s_prev_q & s;
    // Saturating increment of the phase counter.
    assign cnt_inc = (phase_cnt_q == TMO_C) ? TMO_C : phase_cnt_q + ONE_C;

    // Frame decoder. An edge reloads the counter with 1 because the edge
    // cycle itself belongs to the new phase. A timeout fires in the cycle
    // where the count would reach TMO, so the error strobe and
    // phase_cnt==TMO become visible together.
    always_comb begin
        state_d      = state_q;
        phase_cnt_d  = phase_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (!enable) begin
            state_d = WAIT_HIGH;
        end else begin
            case (state_q)
                WAIT_HIGH: begin
                    if (s && primed) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (fall) begin
                        phase_cnt_d = ONE_C;
                        bit_idx_d   = '0;
                        shift_d     = '0;
                        state_d     = LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        if (bit_idx_q < NBITS_C) begin
                            shift_d     = (shift_q << 1) | NBITS'(phase_cnt_q < THR_C);
                            bit_idx_d   = bit_idx_q + IW'(1);
                            phase_cnt_d = ONE_C;
                            state_d     = HIGH;
                        end else if (phase_cnt_q < THR_C) begin
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else if (cnt_inc == TMO_C) begin
                        phase_cnt_d = TMO_C;
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end else begin
                        phase_cnt_d = cnt_inc;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        phase_cnt_d = ONE_C;
                        state_d     = LOW;
                    end else if (cnt_inc == TMO_C) begin
                        phase_cnt_d = TMO_C;
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        phase_cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = WAIT_HIGH;
                end
            endcase
        end
    end

    // State and synchroniser registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q       <= '1;
            primed_q     <= '0;
            s_prev_q     <= 1'b1;
            state_q      <= WAIT_HIGH;
            phase_cnt_q  <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], din};
            primed_q     <= {primed_q[SYNC_STAGES-2:0], 1'b1};
            s_prev_q     <= s;
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == LOW) || (state_q == HIGH);

endmodule

// File: tb/tb_joybus_frame_rx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_joybus_frame_rx
//
// Directed bench for joybus_frame_rx. Instance A uses the default 32-bit,
// 4-clocks-per-microsecond setup. Instance B is the 8-bit,
// 16-clocks-per-microsecond variant. Line timing is expressed in clock
// cycles. One microsecond is 4 cycles on A and 16 cycles on B.
// ----------------------------------------------------------------------------
module tb_joybus_frame_rx;

    logic        clk;
    logic        rstA, enableA, dinA;
    logic [31:0] dataOutA;
    logic        dataValidA, frameErrA, busyA;
    logic        rstB, enableB, dinB;
    logic [7:0]  dataOutB;
    logic        dataValidB, frameErrB, busyB;

    int checks;
    int failures;
    int dvCountA, feCountA, bothA;
    int dvCountB, feCountB, bothB;
    logic [31:0] rxQ[$];

    joybus_frame_rx #(
        .NBITS(32), .CLKS_PER_US(4), .SYNC_STAGES(2), .TIMEOUT_US(8)
    ) dutA (
        .clk_in(clk), .rst(rstA), .enable(enableA), .din(dinA),
        .data_out(dataOutA), .data_valid(dataValidA),
        .frame_err(frameErrA), .busy(busyA)
    );

    joybus_frame_rx #(
        .NBITS(8), .CLKS_PER_US(16), .SYNC_STAGES(2), .TIMEOUT_US(8)
    ) dutB (
        .clk_in(clk), .rst(rstB), .enable(enableB), .din(dinB),
        .data_out(dataOutB), .data_valid(dataValidB),
        .frame_err(frameErrB), .busy(busyB)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (dataValidA === 1'b1) begin
            dvCountA++;
            rxQ.push_back(dataOutA);
        end
        if (frameErrA === 1'b1) feCountA++;
        if (dataValidA === 1'b1 && frameErrA === 1'b1) bothA++;
        if (dataValidB === 1'b1) dvCountB++;
        if (frameErrB === 1'b1) feCountB++;
        if (dataValidB === 1'b1 && frameErrB === 1'b1) bothB++;
    end

    // Drive one line to a level and hold it for a number of cycles.
    task automatic applyStimulus(input bit toB, input logic level, input int cycles);
        if (toB) dinB = level;
        else     dinA = level;
        repeat (cycles) @(negedge clk);
    endtask

    // Send nbits data bits MSB first, with t1 cycles per microsecond.
    task automatic sendBits(input bit toB, input logic [63:0] word, input int nbits, input int t1);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (word[i]) begin
                applyStimulus(toB, 1'b0, t1);
                applyStimulus(toB, 1'b1, 3 * t1);
            end else begin
                applyStimulus(toB, 1'b0, 3 * t1);
                applyStimulus(toB, 1'b1, t1);
            end
        end
    endtask

    task automatic sendFrame(input bit toB, input logic [63:0] word, input int nbits,
                             input int t1, input int stopLow, input int gapHigh);
        sendBits(toB, word, nbits, t1);
        applyStimulus(toB, 1'b0, stopLow);
        applyStimulus(toB, 1'b1, gapHigh);
    endtask

    task automatic test_reset();
        rstA = 1'b1; rstB = 1'b1;
        enableA = 1'b1; enableB = 1'b1;
        dinA = 1'b1; dinB = 1'b1;
        repeat (3) @(negedge clk);
        rstA = 1'b0; rstB = 1'b0;
        checks++;
        if (dataOutA !== 32'h0) begin
            failures++; $display("[TB] FAIL reset_data got=%h want=%h", dataOutA, 32'h0);
        end
        checks++;
        if (dataValidA !== 1'b0 || frameErrA !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_strobes got=%b%b want=00", dataValidA, frameErrA);
        end
        checks++;
        if (busyA !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_busy got=%b want=0", busyA);
        end
        checks++;
        if (dataOutB !== 8'h0 || busyB !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_b got=%h/%b want=00/0", dataOutB, busyB);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_one();
        int dv0, fe0;
        dv0 = dvCountA; fe0 = feCountA;
        sendBits(1'b0, 64'h8000_0000, 32, 4);
        applyStimulus(1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 2);
        checks++;
        if (dataValidA !== 1'b0) begin
            failures++; $display("[TB] FAIL latency_early got=%b want=0", dataValidA);
        end
        applyStimulus(1'b0, 1'b1, 1);
        checks++;
        if (dataValidA !== 1'b1 || dataOutA !== 32'h8000_0000) begin
            failures++; $display("[TB] FAIL single_one got=%b/%h want=1/80000000", dataValidA, dataOutA);
        end
        applyStimulus(1'b0, 1'b1, 1);
        checks++;
        if (dataValidA !== 1'b0) begin
            failures++; $display("[TB] FAIL valid_one_cycle got=%b want=0", dataValidA);
        end
        applyStimulus(1'b0, 1'b1, 10);
        checks++;
        if (dvCountA - dv0 !== 1 || feCountA - fe0 !== 0) begin
            failures++; $display("[TB] FAIL single_counts got=%0d/%0d want=1/0", dvCountA - dv0, feCountA - fe0);
        end
    endtask

    task automatic test_stream();
        logic [31:0] got, want;
        rxQ.delete();
        for (int f = 0; f < 50; f++) begin
            want = (f % 2 == 0) ? 32'hA5A5_5AA5 : 32'h0000_0001;
            sendFrame(1'b0, {32'h0, want}, 32, 4, 4, 20);
        end
        checks++;
        if (rxQ.size() !== 50) begin
            failures++; $display("[TB] FAIL stream_count got=%0d want=50", rxQ.size());
        end
        for (int f = 0; f < 50; f++) begin
            want = (f % 2 == 0) ? 32'hA5A5_5AA5 : 32'h0000_0001;
            got  = (f < rxQ.size()) ? rxQ[f] : 32'hx;
            checks++;
            if (got !== want) begin
                failures++; $display("[TB] FAIL stream_word%0d got=%h want=%h", f, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        rxQ.delete();
        sendBits(1'b0, 64'hA5A5_5AA5, 32, 4);
        applyStimulus(1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 1);
        sendFrame(1'b0, 64'h0000_0001, 32, 4, 4, 10);
        checks++;
        if (rxQ.size() !== 2) begin
            failures++; $display("[TB] FAIL b2b_count got=%0d want=2", rxQ.size());
        end
        checks++;
        if (rxQ.size() != 2 || rxQ[0] !== 32'hA5A5_5AA5 || rxQ[1] !== 32'h0000_0001) begin
            failures++; $display("[TB] FAIL b2b_words got=%p want=a5a55aa5,00000001", rxQ);
        end
    endtask

    task automatic test_enable_abort();
        logic [31:0] prev;
        int fe0;
        prev = dataOutA; fe0 = feCountA;
        sendBits(1'b0, 64'h16, 5, 4);
        applyStimulus(1'b0, 1'b0, 3);
        enableA = 1'b0;
        applyStimulus(1'b0, 1'b0, 3);
        checks++;
        if (busyA !== 1'b0) begin
            failures++; $display("[TB] FAIL enable_busy got=%b want=0", busyA);
        end
        applyStimulus(1'b0, 1'b1, 8);
        enableA = 1'b1;
        applyStimulus(1'b0, 1'b1, 8);
        checks++;
        if (feCountA - fe0 !== 0 || dataOutA !== prev) begin
            failures++; $display("[TB] FAIL enable_silent got=%0d/%h want=0/%h", feCountA - fe0, dataOutA, prev);
        end
        sendFrame(1'b0, 64'hDEAD_BEEF, 32, 4, 4, 10);
        checks++;
        if (dataOutA !== 32'hDEAD_BEEF) begin
            failures++; $display("[TB] FAIL enable_resume got=%h want=deadbeef", dataOutA);
        end
    endtask

    task automatic test_timeout_high();
        logic [31:0] prev;
        int fe0, n;
        prev = dataOutA; fe0 = feCountA;
        sendBits(1'b0, 64'h1FF, 9, 4);
        applyStimulus(1'b0, 1'b0, 4);
        dinA = 1'b1;
        n = 0;
        while (frameErrA !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 34) begin
            failures++; $display("[TB] FAIL timeout_cycle got=%0d want=34", n);
        end
        checks++;
        if (busyA !== 1'b0 || dataOutA !== prev) begin
            failures++; $display("[TB] FAIL timeout_state got=%b/%h want=0/%h", busyA, dataOutA, prev);
        end
        applyStimulus(1'b0, 1'b1, 10);
        checks++;
        if (feCountA - fe0 !== 1) begin
            failures++; $display("[TB] FAIL timeout_count got=%0d want=1", feCountA - fe0);
        end
    endtask

    task automatic test_stop_long();
        logic [31:0] prev;
        int dv0, fe0;
        prev = dataOutA; dv0 = dvCountA; fe0 = feCountA;
        sendFrame(1'b0, 64'h1234_5678, 32, 4, 12, 10);
        sendFrame(1'b0, 64'h1234_5678, 32, 4, 8, 10);
        checks++;
        if (feCountA - fe0 !== 2 || dvCountA - dv0 !== 0) begin
            failures++; $display("[TB] FAIL stop_long got=%0d/%0d want=2/0", feCountA - fe0, dvCountA - dv0);
        end
        checks++;
        if (dataOutA !== prev) begin
            failures++; $display("[TB] FAIL stop_long_data got=%h want=%h", dataOutA, prev);
        end
        sendFrame(1'b0, 64'h1234_5678, 32, 4, 7, 10);
        checks++;
        if (dataOutA !== 32'h1234_5678 || dvCountA - dv0 !== 1) begin
            failures++; $display("[TB] FAIL stop_boundary got=%h/%0d want=12345678/1", dataOutA, dvCountA - dv0);
        end
    endtask

    task automatic test_reset_low_start();
        int dv0, fe0, busySeen;
        rstA = 1'b1;
        dinA = 1'b0;
        repeat (3) @(negedge clk);
        rstA = 1'b0;
        dv0 = dvCountA; fe0 = feCountA;
        checks++;
        if (dataOutA !== 32'h0) begin
            failures++; $display("[TB] FAIL rst_clears_data got=%h want=0", dataOutA);
        end
        busySeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busyA === 1'b1) busySeen++;
        end
        checks++;
        if (busySeen !== 0) begin
            failures++; $display("[TB] FAIL low_start_busy got=%0d want=0", busySeen);
        end
        applyStimulus(1'b0, 1'b1, 8);
        sendFrame(1'b0, 64'h1234_5678, 32, 4, 4, 10);
        checks++;
        if (dataOutA !== 32'h1234_5678 || dvCountA - dv0 !== 1 || feCountA - fe0 !== 0) begin
            failures++; $display("[TB] FAIL low_start_frame got=%h/%0d/%0d want=12345678/1/0",
                                 dataOutA, dvCountA - dv0, feCountA - fe0);
        end
    endtask

    task automatic test_small_reset_mid();
        int dv0, fe0, busySeen;
        dv0 = dvCountB; fe0 = feCountB;
        sendFrame(1'b1, 64'hC3, 8, 16, 16, 10);
        checks++;
        if (dataOutB !== 8'hC3 || dvCountB - dv0 !== 1 || feCountB - fe0 !== 0) begin
            failures++; $display("[TB] FAIL small_c3 got=%h/%0d/%0d want=c3/1/0",
                                 dataOutB, dvCountB - dv0, feCountB - fe0);
        end
        sendBits(1'b1, 64'h2, 3, 16);
        applyStimulus(1'b1, 1'b0, 10);
        rstB = 1'b1;
        applyStimulus(1'b1, 1'b0, 2);
        rstB = 1'b0;
        checks++;
        if (dataOutB !== 8'h00 || busyB !== 1'b0 || dataValidB !== 1'b0) begin
            failures++; $display("[TB] FAIL small_rst got=%h/%b/%b want=00/0/0", dataOutB, busyB, dataValidB);
        end
        busySeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busyB === 1'b1) busySeen++;
        end
        checks++;
        if (busySeen !== 0) begin
            failures++; $display("[TB] FAIL small_wait_high got=%0d want=0", busySeen);
        end
        applyStimulus(1'b1, 1'b1, 20);
        sendFrame(1'b1, 64'h5A, 8, 16, 16, 10);
        checks++;
        if (dataOutB !== 8'h5A) begin
            failures++; $display("[TB] FAIL small_after_rst got=%h want=5a", dataOutB);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        dvCountA = 0; feCountA = 0; bothA = 0;
        dvCountB = 0; feCountB = 0; bothB = 0;
        test_reset();
        test_single_one();
        test_stream();
        test_back_to_back();
        test_enable_abort();
        test_timeout_high();
        test_stop_long();
        test_reset_low_start();
        test_small_reset_mid();
        checks++;
        if (bothA !== 0 || bothB !== 0) begin
            failures++; $display("[TB] FAIL strobe_exclusive got=%0d/%0d want=0/0", bothA, bothB);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
